// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the packet FIFO family.
package fifo_pkg;

   localparam int PKT_W = 10;

   // Pointer width: one extra MSB so that full and empty are distinguishable.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle between the packet producer/consumer and the FIFO.
interface param_sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int WIDTH = PKT_W,
   parameter int DEPTH = 16
);
   logic [WIDTH-1:0]        din;
   logic                    we;
   logic                    re;
   logic                    flush;
   logic                    clr_err;
   logic [WIDTH-1:0]        dout;
   logic                    dout_valid;
   logic                    full;
   logic                    empty;
   logic                    almost_full;
   logic                    almost_empty;
   logic [ptr_w(DEPTH)-1:0] count;
   logic                    overflow;
   logic                    underflow;

   modport master (
      output din, we, re, flush, clr_err,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  din, we, re, flush, clr_err,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ram.sv
// Register-array storage: synchronous write port, asynchronous read address.
module fifo_ram #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage has no reset; valid/empty tracking guarantees stale words are never consumed.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock packet FIFO with occupancy, threshold flags,
// selectable FWFT/registered read, synchronous flush and sticky error flags.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = PKT_W,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 1,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic               clk,
   input  logic               rst,
   param_sync_fifo_if.slave   bus
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be a power of two and at least 4");
   end
   if (AF_THRESH < 0 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_thresh
      $error("param_sync_fifo: thresholds must lie within 0..DEPTH");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             overflow;
   logic             underflow;
   logic [WIDTH-1:0] rd_data;

   // Occupancy falls out of the pointer difference; the MSB makes DEPTH representable.
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == PW'(DEPTH));

   assign push = bus.we & ~full  & ~bus.flush;
   assign pop  = bus.re & ~empty & ~bus.flush;

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (bus.din),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
         // Set has priority over clear so a same-cycle error is never lost.
         if (bus.we & full & ~bus.flush) overflow <= 1'b1;
         else if (bus.clr_err)           overflow <= 1'b0;
         if (bus.re & empty & ~bus.flush) underflow <= 1'b1;
         else if (bus.clr_err)            underflow <= 1'b0;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while there is nothing to show.
      assign bus.dout       = empty ? '0 : rd_data;
      assign bus.dout_valid = ~empty;
   end else begin : g_registered
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= pop;
            if (pop) dout_q <= rd_data;
         end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = valid_q;
   end

   assign bus.count        = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= PW'(AF_THRESH));
   assign bus.almost_empty = (count <= PW'(AE_THRESH));
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: FWFT FIFO against a queue model, plus a registered-read instance.
module tb_param_sync_fifo;
   localparam int W  = 10;
   localparam int D  = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   logic [W-1:0] q [$];
   bit           m_ovf;
   bit           m_udf;

   always #5 clk = ~clk;

   param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) ia ();
   param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) ib ();

   param_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE))
      dut_a (.clk(clk), .rst(rst), .bus(ia));
   param_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE))
      dut_b (.clk(clk), .rst(rst), .bus(ib));

   // {count, full, empty, almost_full, almost_empty, overflow, underflow, dout_valid}
   logic [11:0] obs_a;
   assign obs_a = {ia.count, ia.full, ia.empty, ia.almost_full, ia.almost_empty,
                   ia.overflow, ia.underflow, ia.dout_valid};

   function automatic logic [11:0] exp_status();
      int n = q.size();
      return {5'(n), n == D, n == 0, n >= AF, n <= AE, m_ovf, m_udf, n != 0};
   endfunction

   // One clock of FIFO A: the model applies the operation rules, then the edge happens.
   task automatic cycle_a(input logic we_i, input logic re_i, input logic fl_i,
                          input logic clr_i, input logic [W-1:0] d_i);
      bit was_full  = (q.size() == D);
      bit was_empty = (q.size() == 0);
      ia.we = we_i; ia.re = re_i; ia.flush = fl_i; ia.clr_err = clr_i; ia.din = d_i;
      if (fl_i) q.delete();
      else begin
         if (re_i && !was_empty) void'(q.pop_front());
         if (we_i && !was_full)  q.push_back(d_i);
      end
      if (we_i && was_full && !fl_i) m_ovf = 1'b1;
      else if (clr_i)                m_ovf = 1'b0;
      if (re_i && was_empty && !fl_i) m_udf = 1'b1;
      else if (clr_i)                 m_udf = 1'b0;
      @(posedge clk); #1;
      ia.we = 1'b0; ia.re = 1'b0; ia.flush = 1'b0; ia.clr_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      vectors++;
      if (obs_a !== exp_status()) begin
         miscompares++; $display("FAIL reset_status_a got=%h want=%h", obs_a, exp_status());
      end
      vectors++;
      if (ia.dout !== '0) begin
         miscompares++; $display("FAIL reset_dout_a got=%h want=0", ia.dout);
      end
      vectors++;
      if ({ib.dout, ib.dout_valid, ib.empty, ib.count} !== {10'h0, 1'b0, 1'b1, 5'd0}) begin
         miscompares++; $display("FAIL reset_b got dout=%h dv=%b empty=%b count=%0d want 0/0/1/0",
                                 ib.dout, ib.dout_valid, ib.empty, ib.count);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= D; i++) begin
         cycle_a(1'b1, 1'b0, 1'b0, 1'b0, W'(i));
         vectors++;
         if (obs_a !== exp_status()) begin
            miscompares++; $display("FAIL fill_status[%0d] got=%h want=%h", i, obs_a, exp_status());
         end
      end
      for (int i = 1; i <= D; i++) begin
         vectors++;
         if (ia.dout !== W'(i)) begin
            miscompares++; $display("FAIL drain_data[%0d] got=%h want=%h", i, ia.dout, W'(i));
         end
         cycle_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
         vectors++;
         if (obs_a !== exp_status()) begin
            miscompares++; $display("FAIL drain_status[%0d] got=%h want=%h", i, obs_a, exp_status());
         end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < D; i++) cycle_a(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom_range(0, 'h3FE)));
      cycle_a(1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF);
      vectors++;
      if (obs_a !== exp_status()) begin
         miscompares++; $display("FAIL overflow_status got=%h want=%h", obs_a, exp_status());
      end
      while (q.size() != 0) begin
         vectors++;
         if (ia.dout !== q[0] || ia.dout === 10'h3FF) begin
            miscompares++; $display("FAIL overflow_drain got=%h want=%h", ia.dout, q[0]);
         end
         cycle_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
      end
      cycle_a(1'b0, 1'b0, 1'b0, 1'b1, '0);
      vectors++;
      if (obs_a !== exp_status()) begin
         miscompares++; $display("FAIL overflow_clear got=%h want=%h", obs_a, exp_status());
      end
   endtask

   task automatic test_underflow();
      cycle_a(1'b1, 1'b1, 1'b0, 1'b0, 10'h155);
      vectors++;
      if (obs_a !== exp_status()) begin
         miscompares++; $display("FAIL underflow_status got=%h want=%h", obs_a, exp_status());
      end
      vectors++;
      if (ia.dout !== 10'h155) begin
         miscompares++; $display("FAIL underflow_data got=%h want=155", ia.dout);
      end
      cycle_a(1'b0, 1'b1, 1'b0, 1'b1, '0);
      vectors++;
      if (obs_a !== exp_status()) begin
         miscompares++; $display("FAIL underflow_clear got=%h want=%h", obs_a, exp_status());
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) cycle_a(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
      for (int i = 0; i < 40; i++) begin
         vectors++;
         if (ia.dout !== q[0]) begin
            miscompares++; $display("FAIL stream_data[%0d] got=%h want=%h", i, ia.dout, q[0]);
         end
         cycle_a(1'b1, 1'b1, 1'b0, 1'b0, W'($urandom));
         vectors++;
         if (obs_a !== exp_status() || ia.count !== 5'd5) begin
            miscompares++; $display("FAIL stream_status[%0d] got=%h want=%h", i, obs_a, exp_status());
         end
      end
   endtask

   task automatic test_flush();
      cycle_a(1'b0, 1'b0, 1'b1, 1'b0, '0);
      cycle_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) cycle_a(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
      cycle_a(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C3);
      vectors++;
      if (obs_a !== exp_status() || ia.underflow !== 1'b1) begin
         miscompares++; $display("FAIL flush_status got=%h want=%h", obs_a, exp_status());
      end
      cycle_a(1'b1, 1'b0, 1'b0, 1'b0, 10'h2A5);
      vectors++;
      if (ia.dout !== 10'h2A5 || ia.count !== 5'd1) begin
         miscompares++; $display("FAIL flush_after got dout=%h count=%0d want 2a5/1", ia.dout, ia.count);
      end
      cycle_a(1'b0, 1'b1, 1'b0, 1'b1, '0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int  wp = (i < 200) ? 70 : 30;
         bit  w  = ($urandom_range(0, 99) < wp);
         bit  r  = ($urandom_range(0, 99) < 100 - wp);
         bit  f  = ($urandom_range(0, 39) == 0);
         bit  c  = ($urandom_range(0, 15) == 0);
         cycle_a(w, r, f, c, W'($urandom));
         vectors++;
         if (obs_a !== exp_status()) begin
            miscompares++; $display("FAIL random_status[%0d] got=%h want=%h", i, obs_a, exp_status());
         end
         if (q.size() != 0) begin
            vectors++;
            if (ia.dout !== q[0]) begin
               miscompares++; $display("FAIL random_data[%0d] got=%h want=%h", i, ia.dout, q[0]);
            end
         end
      end
   endtask

   task automatic test_registered_read();
      logic [W-1:0] w0 = W'($urandom);
      logic [W-1:0] w1 = W'($urandom);
      ib.we = 1'b1; ib.din = 10'h0AA;
      @(posedge clk); #1 ib.we = 1'b0;
      vectors++;
      if (ib.dout_valid !== 1'b0 || ib.count !== 5'd1) begin
         miscompares++; $display("FAIL reg_after_write got dv=%b count=%0d want 0/1", ib.dout_valid, ib.count);
      end
      ib.re = 1'b1;
      @(posedge clk); #1 ib.re = 1'b0;
      vectors++;
      if (ib.dout !== 10'h0AA || ib.dout_valid !== 1'b1) begin
         miscompares++; $display("FAIL reg_latency got dout=%h dv=%b want 0aa/1", ib.dout, ib.dout_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if (ib.dout !== 10'h0AA || ib.dout_valid !== 1'b0) begin
         miscompares++; $display("FAIL reg_hold got dout=%h dv=%b want 0aa/0", ib.dout, ib.dout_valid);
      end
      ib.we = 1'b1; ib.din = w0;
      @(posedge clk); #1 ib.din = w1;
      @(posedge clk); #1 ib.we = 1'b0; ib.re = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (ib.dout !== w0 || ib.dout_valid !== 1'b1) begin
         miscompares++; $display("FAIL reg_b2b_0 got dout=%h dv=%b want %h/1", ib.dout, ib.dout_valid, w0);
      end
      @(posedge clk); #1;
      vectors++;
      if (ib.dout !== w1 || ib.dout_valid !== 1'b1) begin
         miscompares++; $display("FAIL reg_b2b_1 got dout=%h dv=%b want %h/1", ib.dout, ib.dout_valid, w1);
      end
      @(posedge clk); #1 ib.re = 1'b0;
      vectors++;
      if (ib.dout_valid !== 1'b0 || ib.underflow !== 1'b1 || ib.dout !== w1) begin
         miscompares++; $display("FAIL reg_empty_read got dv=%b udf=%b dout=%h want 0/1/%h",
                                 ib.dout_valid, ib.underflow, ib.dout, w1);
      end
   endtask

   task automatic test_reset_mid();
      cycle_a(1'b0, 1'b0, 1'b1, 1'b0, '0);
      cycle_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) cycle_a(1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
      ib.we = 1'b1; ib.din = 10'h1E1;
      @(posedge clk); #1 ib.we = 1'b0; ib.re = 1'b1;
      @(posedge clk); #1;
      ia.we = 1'b1; ia.re = 1'b1; ia.flush = 1'b1; ia.din = 10'h077;
      ib.we = 1'b1; ib.re = 1'b1; ib.flush = 1'b1; ib.din = 10'h077;
      rst = 1'b1;
      @(posedge clk); #1;
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      vectors++;
      if (obs_a !== exp_status() || ia.dout !== '0) begin
         miscompares++; $display("FAIL rst_mid_a got=%h dout=%h want=%h dout=0", obs_a, ia.dout, exp_status());
      end
      vectors++;
      if ({ib.dout, ib.dout_valid, ib.count, ib.empty, ib.underflow} !== {10'h0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL rst_mid_b got dout=%h dv=%b count=%0d empty=%b udf=%b want 0/0/0/1/0",
                                 ib.dout, ib.dout_valid, ib.count, ib.empty, ib.underflow);
      end
      ia.we = 1'b0; ia.re = 1'b0; ia.flush = 1'b0;
      ib.we = 1'b0; ib.re = 1'b0; ib.flush = 1'b0;
      rst = 1'b0;
      cycle_a(1'b0, 1'b0, 1'b0, 1'b0, '0);
      vectors++;
      if (obs_a !== exp_status()) begin
         miscompares++; $display("FAIL rst_release_a got=%h want=%h", obs_a, exp_status());
      end
   endtask

   initial begin
      ia.din = '0; ia.we = 1'b0; ia.re = 1'b0; ia.flush = 1'b0; ia.clr_err = 1'b0;
      ib.din = '0; ib.we = 1'b0; ib.re = 1'b0; ib.flush = 1'b0; ib.clr_err = 1'b0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_flush();
      test_random();
      test_registered_read();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
